// File: rtl/arbitro_hamming.sv
// Round-robin arbiter that shares one Hamming(15,11) encoder among N_REQ requesters.
// Optional macro SECDED_EN: out_code[15] carries even overall parity; otherwise it is 0.

module calcula_hamming (
  input  logic [10:0] m,
  output logic [14:0] x
);

  // Parity bits sit at the power-of-two positions x1, x2, x4, x8.
  assign x[0]  = m[0] ^ m[1] ^ m[3] ^ m[4] ^ m[6] ^ m[8] ^ m[10];
  assign x[1]  = m[0] ^ m[2] ^ m[3] ^ m[5] ^ m[6] ^ m[9] ^ m[10];
  assign x[2]  = m[0];
  assign x[3]  = m[1] ^ m[2] ^ m[3] ^ m[7] ^ m[8] ^ m[9] ^ m[10];
  assign x[4]  = m[1];
  assign x[5]  = m[2];
  assign x[6]  = m[3];
  assign x[7]  = m[4] ^ m[5] ^ m[6] ^ m[7] ^ m[8] ^ m[9] ^ m[10];
  assign x[8]  = m[4];
  assign x[9]  = m[5];
  assign x[10] = m[6];
  assign x[11] = m[7];
  assign x[12] = m[8];
  assign x[13] = m[9];
  assign x[14] = m[10];

endmodule

module arbitro_hamming #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [11*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_code,
  output logic [IDW-1:0]       out_id
);

  typedef enum logic [1:0] {
    OCIOSO,
    CODIFICA,
    ENTREGA
  } estado_t;

  estado_t          estado;
  estado_t          estado_sig;
  logic [IDW-1:0]   ultimo;
  logic [IDW-1:0]   gsel;
  logic [IDW-1:0]   id_cap;
  logic             hay;
  logic [N_REQ-1:0] grant;
  logic [10:0]      dato_sel;
  logic [10:0]      dato_cap;
  logic [14:0]      cod15;
  logic             paridad;

  // Scan starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    int s;
    s    = 0;
    hay  = 1'b0;
    gsel = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      s = int'(ultimo) + k;
      if (s >= N_REQ) begin
        s = s - N_REQ;
      end
      if (!hay && req_valid[IDW'(s)]) begin
        hay  = 1'b1;
        gsel = IDW'(s);
      end
    end
  end

  always_comb begin
    grant    = '0;
    dato_sel = '0;
    if ((estado == OCIOSO) && hay && !rst) begin
      grant[gsel] = 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gsel == IDW'(i)) begin
        dato_sel = req_data[11*i +: 11];
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    estado_sig = estado;
    case (estado)
      OCIOSO:   if (hay) estado_sig = CODIFICA;
      CODIFICA: estado_sig = ENTREGA;
      ENTREGA:  if (out_ready) estado_sig = OCIOSO;
      default:  estado_sig = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  calcula_hamming u_enc (
    .m (dato_cap),
    .x (cod15)
  );

`ifdef SECDED_EN
  assign paridad = ^cod15;
`else
  assign paridad = 1'b0;
`endif

  // Captured word and id stay put until the next grant; output is held through back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      ultimo    <= IDW'(N_REQ - 1);
      dato_cap  <= '0;
      id_cap    <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_id    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (hay) begin
            dato_cap <= dato_sel;
            id_cap   <= gsel;
            ultimo   <= gsel;
          end
        end
        CODIFICA: begin
          out_code  <= {paridad, cod15};
          out_id    <= id_cap;
          out_valid <= 1'b1;
        end
        ENTREGA: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
